// File: rtl/ram_fill_engine.sv
// RAM fill engine: muxes a CPU write port with a hardware block-fill sequencer.
// Optional feature macro RAM_FILL_INCR_EN adds an incr input for incrementing fill data.
module ram_fill_engine #(
    parameter int Nloc  = 16,
    parameter int Dbits = 4,
    localparam int AW   = (Nloc > 1) ? $clog2(Nloc) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      count,
    input  logic [Dbits-1:0] value,
`ifdef RAM_FILL_INCR_EN
    input  logic             incr,
`endif
    input  logic             abort,
    input  logic             cpu_wr,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [Dbits-1:0] cpu_din,
    output logic             cpu_stall,
    output logic             busy,
    output logic             done,
    output logic             ram_wr,
    output logic [AW-1:0]    ram_addr,
    output logic [Dbits-1:0] ram_din,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [AW-1:0]    addr_q, addr_n;
    logic [AW:0]      left_q, left_n;
    logic [Dbits-1:0] data_q, data_n;
    logic             step_q, step_n;
    logic             incr_in;

`ifdef RAM_FILL_INCR_EN
    assign incr_in = incr;
`else
    assign incr_in = 1'b0;
`endif

    assign fsm_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= '0;
            left_q <= '0;
            data_q <= '0;
            step_q <= 1'b0;
        end else begin
            state  <= state_n;
            addr_q <= addr_n;
            left_q <= left_n;
            data_q <= data_n;
            step_q <= step_n;
        end
    end

    always_comb begin
        state_n   = state;
        addr_n    = addr_q;
        left_n    = left_q;
        data_n    = data_q;
        step_n    = step_q;
        ram_wr    = 1'b0;
        ram_addr  = addr_q;
        ram_din   = data_q;
        cpu_stall = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ram_wr   = cpu_wr;
                ram_addr = cpu_addr;
                ram_din  = cpu_din;
                if (start) begin
                    if (count != '0) begin
                        addr_n  = base_addr;
                        left_n  = count;
                        data_n  = value;
                        step_n  = incr_in;
                        state_n = FILL;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            FILL: begin
                busy      = 1'b1;
                cpu_stall = cpu_wr;
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    ram_wr = 1'b1;
                    // Explicit compare keeps the wrap correct when Nloc is not a power of two.
                    addr_n = (addr_q == AW'(Nloc - 1)) ? '0 : addr_q + 1'b1;
                    left_n = left_q - 1'b1;
                    data_n = data_q + Dbits'(step_q);
                    if (left_q == 1) state_n = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                cpu_stall = cpu_wr;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (reset) ram_wr = 1'b0;
    end

endmodule
